// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer; control bits read zero on every bubble.
module pipe_stage_reg #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 12,
    parameter int unsigned SKID_EN    = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CTRL_WIDTH-1:0] out_ctrl_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  discard;
    logic                  out_valid_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic [CTRL_WIDTH-1:0] skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_d;

    // With a skid slot, ready depends only on occupancy; without one it must look downstream.
    if (SKID_EN != 0) begin : g_ready_skid
        assign in_ready_o = (state_q != TWO) && !flush_i;
    end else begin : g_ready_single
        assign in_ready_o = (!out_valid_o || out_ready_i) && !flush_i;
    end

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;
    assign discard  = flush_i && ((state_q == TWO) || ((state_q == ONE) && !out_ready_i));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next payload contents; flush dominates everything else.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = out_ctrl_o;
        main_data_d = out_data_o;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (in_xfer) begin
                        state_d     = TWO;
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                    end else if (out_xfer) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                end
            endcase
        end
        out_valid_d = (state_d != EMPTY);
    end

    // Main output register; data keeps its last value across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_ctrl_o  <= '0;
            out_data_o  <= '0;
        end else begin
            out_valid_o <= out_valid_d;
            out_ctrl_o  <= main_ctrl_d;
            out_data_o  <= main_data_d;
        end
    end

    if (SKID_EN != 0) begin : g_skid
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end else begin
                skid_ctrl_q <= skid_ctrl_d;
                skid_data_q <= skid_data_d;
            end
        end
    end else begin : g_no_skid
        assign skid_ctrl_q = '0;
        assign skid_data_q = '0;
    end

    // Saturating count of flushes that threw away an untransferred entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_o <= '0;
        end else if (discard && (flush_cnt_o != '1)) begin
            flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no skid, 2-bit counter) checked against
// a small FIFO reference model under directed and random traffic.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [11:0] in_ctrl   [3];
    logic [31:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [11:0] out_ctrl  [3];
    logic [31:0] out_data  [3];
    logic        flush     [3];
    logic [7:0]  cnt_w     [3];
    logic [1:0]  cnt_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per instance a FIFO of up to cap entries plus the last head data.
    logic [11:0] mq_ctrl [3][2];
    logic [31:0] mq_data [3][2];
    int          mcount  [3];
    int          mcnt    [3];
    logic [31:0] mlast   [3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(12), .SKID_EN(1), .CNT_WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .flush_i(flush[0]), .in_valid_i(in_valid[0]),
        .in_ready_o(in_ready[0]), .in_ctrl_i(in_ctrl[0]), .in_data_i(in_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_ctrl_o(out_ctrl[0]),
        .out_data_o(out_data[0]), .flush_cnt_o(cnt_w[0]));

    pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(12), .SKID_EN(0), .CNT_WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .flush_i(flush[1]), .in_valid_i(in_valid[1]),
        .in_ready_o(in_ready[1]), .in_ctrl_i(in_ctrl[1]), .in_data_i(in_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_ctrl_o(out_ctrl[1]),
        .out_data_o(out_data[1]), .flush_cnt_o(cnt_w[1]));

    pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(12), .SKID_EN(1), .CNT_WIDTH(2)) u_dut_c (
        .clk(clk), .rst(rst), .flush_i(flush[2]), .in_valid_i(in_valid[2]),
        .in_ready_o(in_ready[2]), .in_ctrl_i(in_ctrl[2]), .in_data_i(in_data[2]),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_ctrl_o(out_ctrl[2]),
        .out_data_o(out_data[2]), .flush_cnt_o(cnt_c));

    assign cnt_w[2] = {6'd0, cnt_c};

    function automatic int cap_of(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 2) ? 3 : 255;
    endfunction

    function automatic logic m_ready(input int i, input logic r, input logic f);
        if (f) return 1'b0;
        if (i == 1) return (mcount[i] == 0) || r;
        return mcount[i] < cap_of(i);
    endfunction

    function automatic logic exp_valid(input int i);
        return mcount[i] > 0;
    endfunction

    function automatic logic [11:0] exp_ctrl(input int i);
        return (mcount[i] > 0) ? mq_ctrl[i][0] : 12'd0;
    endfunction

    function automatic logic [7:0] exp_cnt(input int i);
        return 8'(mcnt[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mcount[i] = 0;
            mcnt[i]   = 0;
            mlast[i]  = 32'd0;
        end
    endtask

    function automatic logic [11:0] rand_ctrl();
        return 12'($urandom) | 12'h001;
    endfunction

    // One clock of stimulus on instance i; returns observed and modelled in_ready.
    task automatic step(input int i, input logic v, input logic [11:0] c, input logic [31:0] d,
                        input logic r, input logic f, output logic ro, output logic re);
        logic ox;
        @(negedge clk);
        in_valid[i]  = v;
        in_ctrl[i]   = c;
        in_data[i]   = d;
        out_ready[i] = r;
        flush[i]     = f;
        #2;
        ro = in_ready[i];
        re = m_ready(i, r, f);
        ox = (mcount[i] > 0) && r;
        @(posedge clk);
        if (ox) begin
            mq_ctrl[i][0] = mq_ctrl[i][1];
            mq_data[i][0] = mq_data[i][1];
            mcount[i]--;
        end
        if (f) begin
            if (mcount[i] > 0 && mcnt[i] < cmax_of(i)) mcnt[i]++;
            mcount[i] = 0;
        end else if (v && re) begin
            mq_ctrl[i][mcount[i]] = c;
            mq_data[i][mcount[i]] = d;
            mcount[i]++;
        end
        if (mcount[i] > 0) mlast[i] = mq_data[i][0];
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_ctrl[i] = '0; in_data[i] = '0;
            out_ready[i] = 1'b0; flush[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid[i] !== 1'b0 || out_ctrl[i] !== 12'd0 || out_data[i] !== 32'd0 ||
                cnt_w[i] !== 8'd0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got v=%b c=%h d=%h n=%h want all zero",
                         i, out_valid[i], out_ctrl[i], out_data[i], cnt_w[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (in_ready[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ready[%0d]: got %b want 1", i, in_ready[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] vals [3];
        logic ro, re;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, rand_ctrl(), vals[k], 1'b1, 1'b0, ro, re);
            n_cmp++;
            if (ro !== 1'b1 || out_valid[0] !== 1'b1 || out_data[0] !== vals[k] ||
                out_ctrl[0] !== exp_ctrl(0)) begin
                n_bad++;
                $display("FAIL stream[%0d]: got r=%b v=%b d=%h c=%h want r=1 v=1 d=%h c=%h",
                         k, ro, out_valid[0], out_data[0], out_ctrl[0], vals[k], exp_ctrl(0));
            end
        end
        step(0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, ro, re);
        n_cmp++;
        if (out_valid[0] !== 1'b0 || out_ctrl[0] !== 12'd0 || out_data[0] !== 32'h33) begin
            n_bad++;
            $display("FAIL stream_drain: got v=%b c=%h d=%h want v=0 c=0 d=33",
                     out_valid[0], out_ctrl[0], out_data[0]);
        end
    endtask

    task automatic test_skid();
        logic ro, re;
        step(0, 1'b1, rand_ctrl(), 32'hA, 1'b0, 1'b0, ro, re);
        step(0, 1'b1, rand_ctrl(), 32'hB, 1'b0, 1'b0, ro, re);
        step(0, 1'b1, rand_ctrl(), 32'hC, 1'b0, 1'b0, ro, re);
        n_cmp++;
        if (ro !== 1'b0 || out_data[0] !== 32'hA || out_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL skid_full: got r=%b v=%b d=%h want r=0 v=1 d=a",
                     ro, out_valid[0], out_data[0]);
        end
        step(0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, ro, re);
        n_cmp++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hB || out_ctrl[0] !== exp_ctrl(0)) begin
            n_bad++;
            $display("FAIL skid_order: got v=%b d=%h c=%h want v=1 d=b c=%h",
                     out_valid[0], out_data[0], out_ctrl[0], exp_ctrl(0));
        end
        step(0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, ro, re);
        n_cmp++;
        if (out_valid[0] !== 1'b0 || out_ctrl[0] !== 12'd0) begin
            n_bad++;
            $display("FAIL skid_drain: got v=%b c=%h want v=0 c=0", out_valid[0], out_ctrl[0]);
        end
    endtask

    task automatic test_no_skid();
        logic ro, re;
        step(1, 1'b1, rand_ctrl(), 32'h5A, 1'b0, 1'b0, ro, re);
        for (int k = 0; k < 5; k++) begin
            step(1, 1'b1, rand_ctrl(), $urandom, 1'b0, 1'b0, ro, re);
            n_cmp++;
            if (ro !== 1'b0 || out_valid[1] !== 1'b1 || out_data[1] !== 32'h5A) begin
                n_bad++;
                $display("FAIL noskid_stall[%0d]: got r=%b v=%b d=%h want r=0 v=1 d=5a",
                         k, ro, out_valid[1], out_data[1]);
            end
        end
        step(1, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, ro, re);
        n_cmp++;
        if (out_valid[1] !== 1'b0 || out_ctrl[1] !== 12'd0) begin
            n_bad++;
            $display("FAIL noskid_drain: got v=%b c=%h want v=0 c=0", out_valid[1], out_ctrl[1]);
        end
    endtask

    task automatic test_flush();
        logic ro, re;
        step(0, 1'b1, rand_ctrl(), 32'h1, 1'b0, 1'b0, ro, re);
        step(0, 1'b1, rand_ctrl(), 32'h2, 1'b0, 1'b0, ro, re);
        step(0, 1'b1, rand_ctrl(), 32'h3, 1'b0, 1'b1, ro, re);
        n_cmp++;
        if (ro !== 1'b0 || out_valid[0] !== 1'b0 || out_ctrl[0] !== 12'd0 ||
            cnt_w[0] !== 8'd1 || out_data[0] !== 32'h1) begin
            n_bad++;
            $display("FAIL flush_two: got r=%b v=%b c=%h n=%0d d=%h want r=0 v=0 c=0 n=1 d=1",
                     ro, out_valid[0], out_ctrl[0], cnt_w[0], out_data[0]);
        end
        step(0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, ro, re);
        n_cmp++;
        if (out_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_no_accept: got v=%b want 0", out_valid[0]);
        end
    endtask

    task automatic test_saturate();
        logic ro, re;
        for (int k = 0; k < 5; k++) begin
            step(2, 1'b1, rand_ctrl(), 32'(k), 1'b0, 1'b0, ro, re);
            step(2, 1'b0, 12'd0, 32'd0, 1'b0, 1'b1, ro, re);
            n_cmp++;
            if (cnt_w[2] !== exp_cnt(2)) begin
                n_bad++;
                $display("FAIL sat_count[%0d]: got %0d want %0d", k, cnt_w[2], exp_cnt(2));
            end
        end
        step(2, 1'b0, 12'd0, 32'd0, 1'b0, 1'b1, ro, re);
        n_cmp++;
        if (cnt_w[2] !== 8'd3) begin
            n_bad++;
            $display("FAIL sat_empty_flush: got %0d want 3", cnt_w[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic ro, re;
        step(0, 1'b1, rand_ctrl(), 32'hD1, 1'b0, 1'b0, ro, re);
        step(0, 1'b1, rand_ctrl(), 32'hD2, 1'b0, 1'b0, ro, re);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || out_ctrl[0] !== 12'd0 || out_data[0] !== 32'd0 ||
            cnt_w[0] !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_async: got v=%b c=%h d=%h n=%0d want all zero",
                     out_valid[0], out_ctrl[0], out_data[0], cnt_w[0]);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(0, 1'b1, rand_ctrl(), 32'hE0 + 32'(k), 1'b1, 1'b0, ro, re);
            n_cmp++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== 32'hE0 + 32'(k)) begin
                n_bad++;
                $display("FAIL reset_resume[%0d]: got v=%b d=%h want v=1 d=%h",
                         k, out_valid[0], out_data[0], 32'hE0 + 32'(k));
            end
        end
    endtask

    task automatic test_random();
        logic ro, re;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 400; n++) begin
                step(i, $urandom_range(0, 9) < 7, rand_ctrl(), $urandom,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, ro, re);
                n_cmp++;
                if (ro !== re || out_valid[i] !== exp_valid(i) || out_ctrl[i] !== exp_ctrl(i) ||
                    out_data[i] !== mlast[i] || cnt_w[i] !== exp_cnt(i)) begin
                    n_bad++;
                    $display("FAIL random[%0d.%0d]: got r=%b v=%b c=%h d=%h n=%0d want r=%b v=%b c=%h d=%h n=%0d",
                             i, n, ro, out_valid[i], out_ctrl[i], out_data[i], cnt_w[i],
                             re, exp_valid(i), exp_ctrl(i), mlast[i], exp_cnt(i));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_skid();
        test_no_skid();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
